lwe_decrypt: RTL and testbench

//  Decrypts one LWE ciphertext to a plaintext: m = round((b - <a,s>) * p/q) mod p.

---
 rtl/lwe_pkg.sv | 37 +++
 rtl/lwe_mod_mac.sv | 24 ++
 rtl/lwe_decrypt.sv | 128 ++++++++++++
 tb/tb_lwe_decrypt.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lwe_pkg.sv
// Shared definitions for the LWE blocks: FSM states and parameter helpers.
// Helpers derive the scaling shift and rounding offset from q and p.
package lwe_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        SCALE,
        DONE
    } lwe_state_e;

    // Exact log2 of a power of two.
    function automatic int lwe_log2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) == v) r = i;
        end
        return r;
    endfunction

    // Right shift that maps Z_q onto Z_p: log2(q/p).
    function automatic int delta_shift(input int q, input int p);
        return lwe_log2(q / p);
    endfunction

    // Half a plaintext step in ciphertext units, for round-to-nearest.
    function automatic int round_half(input int q, input int p);
        return q / (2 * p);
    endfunction

    // Width of the key element index (never zero).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lwe_mod_mac.sv
// Combinational acc - a*s mod q, with q = 2**LQ.
// Ports: acc_i running value, a_i/s_i signed elements, acc_o result.
module lwe_mod_mac #(
    parameter int CW = 21,
    parameter int LQ = 10
) (
    input  logic [LQ-1:0] acc_i,
    input  logic [CW-1:0] a_i,
    input  logic [CW-1:0] s_i,
    output logic [LQ-1:0] acc_o
);

    logic signed [2*CW-1:0] a_x;
    logic signed [2*CW-1:0] s_x;
    logic        [LQ-1:0]   prod_lo;

    assign a_x = {{CW{a_i[CW-1]}}, a_i};
    assign s_x = {{CW{s_i[CW-1]}}, s_i};

    // Only the low log2(q) bits matter after the mod-q reduction.
    assign prod_lo = LQ'(a_x * s_x);
    assign acc_o   = acc_i - prod_lo;

endmodule

// File: rtl/lwe_decrypt.sv
// LWE decryption: plaintext = round((b - <a,s>) * p/q) mod p, one MAC/cycle.
// Ports: clk, rst_n, in_valid/in_ready + ciphertext/secret_key in,
//        out_valid/out_ready + plaintext out.
module lwe_decrypt
    import lwe_pkg::*;
#(
    parameter int PLAINTEXT_MODULUS  = 64,
    parameter int PLAINTEXT_WIDTH    = 6,
    parameter int DIMENSION          = 1,
    parameter int CIPHERTEXT_MODULUS = 1024,
    parameter int CIPHERTEXT_WIDTH   = 21,
    parameter int BIG_N              = 30
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic [(DIMENSION+1)*CIPHERTEXT_WIDTH-1:0]   ciphertext,
    input  logic [DIMENSION*CIPHERTEXT_WIDTH-1:0]       secret_key,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [PLAINTEXT_WIDTH-1:0]                  plaintext
);

    localparam int CW = CIPHERTEXT_WIDTH;
    localparam int LQ = lwe_log2(CIPHERTEXT_MODULUS);
    localparam int LP = PLAINTEXT_WIDTH;
    localparam int DS = delta_shift(CIPHERTEXT_MODULUS, PLAINTEXT_MODULUS);
    localparam int RH = round_half(CIPHERTEXT_MODULUS, PLAINTEXT_MODULUS);
    localparam int IW = idx_width(DIMENSION);
    localparam int NE = 1 << IW;
    localparam int unused_big_n = BIG_N;

    lwe_state_e              state_q;
    logic [LQ-1:0]           acc_q;
    logic [LQ-1:0]           acc_d;
    logic [IW-1:0]           idx_q;
    logic [DIMENSION*CW-1:0] a_q;
    logic [DIMENSION*CW-1:0] s_q;
    logic                    in_ready_q;
    logic                    out_valid_q;
    logic [LP-1:0]           pt_q;
    logic [LP-1:0]           pt_d;
    logic [LQ:0]             round_sum;
    logic                    unused_b;

    // b's bits above log2(q) vanish in the mod-q reduction.
    assign unused_b = ^ciphertext[CW-1:LQ];

    // Element tables padded to a power of two so idx_q indexes cleanly.
    logic [CW-1:0] a_arr [NE];
    logic [CW-1:0] s_arr [NE];

    for (genvar g = 0; g < NE; g++) begin : g_elem
        if (g < DIMENSION) begin : g_live
            assign a_arr[g] = a_q[g*CW +: CW];
            assign s_arr[g] = s_q[g*CW +: CW];
        end else begin : g_pad
            assign a_arr[g] = '0;
            assign s_arr[g] = '0;
        end
    end

    lwe_mod_mac #(
        .CW (CW),
        .LQ (LQ)
    ) u_mac (
        .acc_i (acc_q),
        .a_i   (a_arr[idx_q]),
        .s_i   (s_arr[idx_q]),
        .acc_o (acc_d)
    );

    // Extra top bit keeps the rounding carry; it is dropped mod p.
    assign round_sum = {1'b0, acc_q} + (LQ+1)'(RH);
    assign pt_d      = LP'(round_sum >> DS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            idx_q       <= '0;
            a_q         <= '0;
            s_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            pt_q        <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= ciphertext[(DIMENSION+1)*CW-1:CW];
                        s_q        <= secret_key;
                        acc_q      <= ciphertext[LQ-1:0];
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= MAC;
                    end
                end
                MAC: begin
                    acc_q <= acc_d;
                    if (idx_q == IW'(DIMENSION - 1)) begin
                        state_q <= SCALE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                SCALE: begin
                    pt_q        <= pt_d;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign plaintext = pt_q;

endmodule

// File: tb/tb_lwe_decrypt.sv
// Scoreboard bench for lwe_decrypt: DIMENSION=1 and DIMENSION=4 instances.
// Reference model does the textbook rounding with integer arithmetic.
module tb_lwe_decrypt;

    localparam int CW = 21;
    localparam longint Q = 1024;
    localparam longint P = 64;

    typedef struct {
        logic [5:0] pt;
        int         acc_cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         rstn  [2];
    logic         iv    [2];
    logic         ir    [2];
    logic         ov    [2];
    logic         ordy  [2];
    logic [5:0]   pt    [2];
    logic         hold  [2];
    logic [41:0]  ct0;
    logic [20:0]  key0;
    logic [104:0] ct1;
    logic [83:0]  key1;

    exp_t sb [2][$];
    logic prev_ov [2];
    logic [5:0] prev_pt [2];

    int nchk  = 0;
    int nfail = 0;

    lwe_decrypt #(.DIMENSION(1)) dut1 (
        .clk        (clk),
        .rst_n      (rstn[0]),
        .in_valid   (iv[0]),
        .in_ready   (ir[0]),
        .ciphertext (ct0),
        .secret_key (key0),
        .out_valid  (ov[0]),
        .out_ready  (ordy[0]),
        .plaintext  (pt[0])
    );

    lwe_decrypt #(.DIMENSION(4)) dut4 (
        .clk        (clk),
        .rst_n      (rstn[1]),
        .in_valid   (iv[1]),
        .in_ready   (ir[1]),
        .ciphertext (ct1),
        .secret_key (key1),
        .out_valid  (ov[1]),
        .out_ready  (ordy[1]),
        .plaintext  (pt[1])
    );

    function automatic logic [5:0] model(input int d, input longint b,
                                         input longint a[4], input longint s[4]);
        longint v;
        v = b;
        for (int i = 0; i < d; i++) v = v - a[i] * s[i];
        v = ((v % Q) + Q) % Q;
        return 6'(((v * P + Q / 2) / Q) % P);
    endfunction

    function automatic longint r21();
        logic signed [20:0] t;
        t = 21'($urandom);
        return longint'(t);
    endfunction

    task automatic check(input string name, input int got, input int want);
        nchk++;
        if (got != want) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic send(input int k, input longint b,
                        input longint a[4], input longint s[4]);
        exp_t e;
        int n;
        e.pt = model((k == 0) ? 1 : 4, b, a, s);
        if (k == 0) begin
            ct0  = {a[0][20:0], b[20:0]};
            key0 = s[0][20:0];
        end else begin
            ct1[20:0] = b[20:0];
            for (int i = 0; i < 4; i++) begin
                ct1[(i+1)*CW +: CW] = a[i][20:0];
                key1[i*CW +: CW]    = s[i][20:0];
            end
        end
        iv[k] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!ir[k] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ir[k]) begin
            nchk++;
            nfail++;
            $display("FAIL accept_timeout dut%0d: in_ready got 0 expected 1", k);
            iv[k] = 1'b0;
            return;
        end
        e.acc_cyc = cyc;
        sb[k].push_back(e);
        @(posedge clk);
        #1;
        iv[k] = 1'b0;
    endtask

    task automatic mon(input int k);
        exp_t e;
        int d;
        d = (k == 0) ? 1 : 4;
        if (!rstn[k]) begin
            prev_ov[k] = 1'b0;
            return;
        end
        if (ov[k] && !prev_ov[k]) begin
            if (sb[k].size() == 0) begin
                nchk++;
                nfail++;
                $display("FAIL unexpected_out dut%0d: got value %0d expected none", k, pt[k]);
            end else begin
                check($sformatf("latency_dut%0d", k), cyc - sb[k][0].acc_cyc, d + 2);
            end
        end else if (ov[k] && prev_ov[k]) begin
            check($sformatf("held_stable_dut%0d", k), int'(pt[k]), int'(prev_pt[k]));
        end
        if (ov[k] && ordy[k] && sb[k].size() > 0) begin
            e = sb[k].pop_front();
            check($sformatf("plaintext_dut%0d", k), int'(pt[k]), int'(e.pt));
        end
        prev_ov[k] = ov[k];
        prev_pt[k] = pt[k];
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    initial begin
        ordy[0] = 1'b0;
        ordy[1] = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++)
                ordy[k] = hold[k] ? 1'b0 : ($urandom_range(0, 2) != 0);
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while ((sb[0].size() != 0 || sb[1].size() != 0) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (sb[0].size() != 0 || sb[1].size() != 0) begin
            nchk++;
            nfail++;
            $display("FAIL drain_timeout: pending %0d/%0d expected 0/0",
                     sb[0].size(), sb[1].size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        longint z[4];
        longint a[4];
        longint s[4];
        longint bv[6];
        longint av[6];
        longint sv[6];
        z = '{0, 0, 0, 0};
        for (int k = 0; k < 2; k++) begin
            rstn[k] = 1'b0;
            iv[k] = 1'b0;
            hold[k] = 1'b0;
            prev_ov[k] = 1'b0;
            prev_pt[k] = '0;
        end
        ct0 = '0;
        key0 = '0;
        ct1 = '0;
        key1 = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_in_ready_dut%0d", k), int'(ir[k]), 1);
            check($sformatf("rst_out_valid_dut%0d", k), int'(ov[k]), 0);
            check($sformatf("rst_plaintext_dut%0d", k), int'(pt[k]), 0);
        end
        @(negedge clk);
        rstn[0] = 1'b1;
        rstn[1] = 1'b1;
        @(posedge clk);
        #1;

        // Clean decrypt under 10 cycles of backpressure with busy pulses.
        hold[0] = 1'b1;
        send(0, 607, '{5, 0, 0, 0}, '{3, 0, 0, 0});
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("busy_in_ready", int'(ir[0]), 0);
            iv[0] = 1'b1;
            ct0 = 42'({$urandom(), $urandom()});
            key0 = 21'($urandom());
        end
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        hold[0] = 1'b0;
        drain();

        // Rounding and wrap corners.
        bv = '{610, 599, 598, 1016, -3, 1023};
        av = '{5, 5, 5, 0, 0, 0};
        sv = '{3, 3, 3, 0, 0, 0};
        for (int i = 0; i < 6; i++) begin
            a = '{av[i], 0, 0, 0};
            s = '{sv[i], 0, 0, 0};
            send(0, bv[i], a, s);
        end

        send(1, 300 + 16 * 5, '{10, 20, 30, 40}, '{1, 2, 3, 4});
        drain();

        // Random back-to-back streams on both instances.
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    longint ra[4];
                    longint rs[4];
                    ra = '{r21(), 0, 0, 0};
                    rs = '{r21(), 0, 0, 0};
                    send(0, r21(), ra, rs);
                end
            end
            begin
                for (int i = 0; i < 8; i++) begin
                    longint ra[4];
                    longint rs[4];
                    for (int j = 0; j < 4; j++) begin
                        ra[j] = r21();
                        rs[j] = r21();
                    end
                    send(1, r21(), ra, rs);
                end
            end
        join
        drain();

        // Reset in the middle of the MAC phase.
        send(1, 555, '{7, 8, 9, 10}, '{11, 12, 13, 14});
        @(posedge clk);
        #1;
        rstn[1] = 1'b0;
        #1;
        check("midrst_out_valid", int'(ov[1]), 0);
        check("midrst_in_ready", int'(ir[1]), 1);
        void'(sb[1].pop_back());
        @(negedge clk);
        rstn[1] = 1'b1;
        @(posedge clk);
        #1;
        for (int j = 0; j < 4; j++) begin
            a[j] = r21();
            s[j] = r21();
        end
        send(1, r21(), a, s);
        send(1, 300 + 16 * 5, '{10, 20, 30, 40}, '{1, 2, 3, 4});
        send(0, 607, '{5, 0, 0, 0}, '{3, 0, 0, 0});
        drain();
        repeat (5) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
